pipe_hazard_ctrl: RTL
=====================

// Module: pipe_hazard_ctrl
// PURPOSE
//  Hazard and sequencing controller for the 5-stage RV32I pipeline (IF/ID/EX/MEM/WB).
//  Drives the stall/flush controls of every inter-stage register and the EX operand-forwarding selects.
//  Stall/flush controls: stall = hold contents; flush = load zeros (bubble).
//  Handles load-use bubbles, branch-mispredict redirect, multi-cycle data-memory waits and a memory-wait watchdog.
// PARAMETERS
//  MEM_TIMEOUT  255  MWAIT cycles before abort; 1..65535
//  REDIR_LAT    1    extra fetch-redirect cycles after mispredict; 0..15; 0 = no REDIR state
// PORTS
//  CLK            in   1   clock, rising edge
//  RST_N          in   1   synchronous reset, active low
//  rs1D, rs2D     in   5   source regs of instr in ID
//  use_rs1D/2D    in   1   ID instr reads rs1/rs2
//  rs1E, rs2E     in   5   source regs of instr in EX
//  rdE            in   5   dest of instr in EX
//  reg_writeE     in   1   EX instr writes rd
//  mem_loadE      in   3   EX load type; nonzero = load
//  fail_predictE  in   1   EX branch mispredicted
//  rdM            in   5   dest of instr in MEM
//  reg_writeM     in   1   MEM instr writes rd
//  mem_loadM      in   3   MEM load type; nonzero = load
//  mem_storeM     in   2   MEM store type; nonzero = store
//  mem_readyM     in   1   data memory completes access this cycle
//  rdW            in   5   dest of instr in WB
//  reg_writeW     in   1   WB instr writes rd
//  stallF/D/E/M   out  1   hold PC, IF/ID, ID/EX, EX/MEM
//  flushD/E/W     out  1   bubble into IF/ID, ID/EX, MEM/WB
//  fwd_aE, fwd_bE out  2   00 regfile, 01 from MEM result, 10 from WB data
//  mem_err        out  1   sticky: watchdog fired
// BEHAVIOUR
//  - Outputs are Mealy: combinational from state + inputs. State and counters change only on CLK.
//  - Reset (RST_N=0 at edge):
//      state=RUN; counters=0; mem_err=0.
//      While RST_N=0: stalls=0, flushD=flushE=flushW=1, fwd=00.
//  - States: RUN, MWAIT, REDIR.
//  - Memory access in M: acc = (mem_loadM!=0)|(mem_storeM!=0).
//  - Priority, highest first: memory wait > mispredict > load-use.
//  - Memory wait (RUN, or MWAIT):
//      Trigger: acc && !mem_readyM.
//      Outputs: stallF=stallD=stallE=stallM=1, flushW=1.
//      RUN->MWAIT.
//      MWAIT holds until mem_readyM=1. In that cycle: no stall, ->RUN.
//      fail_predictE and load-use are ignored while stalled; EX re-presents them later.
//  - Watchdog:
//      wcnt increments per MWAIT cycle.
//      At wcnt==MEM_TIMEOUT-1: mem_err<=1, release the stall, ->RUN, wcnt<=0.
//      wcnt clears on every MWAIT exit.
//  - Mispredict (RUN, no mem stall, fail_predictE=1):
//      flushD=flushE=1, no stalls.
//      If REDIR_LAT>0: ->REDIR, rcnt<=REDIR_LAT.
//  - REDIR:
//      flushD=1 every cycle (squash wrong-path fetch).
//      rcnt decrements each cycle; ->RUN when rcnt==1.
//      A memory wait arising in REDIR takes priority, stalls, and freezes rcnt.
//  - Load-use (RUN, no higher event):
//      Condition: mem_loadE!=0 && reg_writeE && rdE!=0 && ((use_rs1D&&rs1D==rdE)|(use_rs2D&&rs2D==rdE)).
//      Outputs: stallF=stallD=1, flushE=1 for exactly that cycle. No state change.
//  - Forwarding (fwd_aE shown; fwd_bE identical with rs2E):
//      01 if reg_writeM && rdM!=0 && rdM==rs1E && mem_loadM==0.
//      Else 10 if reg_writeW && rdW!=0 && rdW==rs1E.
//      Else 00.
//      MEM beats WB on a double match.
// CONFIGURATION
//  - Macro PIPE_PERF_CNT_EN defined: adds outputs perf_stall[31:0], perf_flush[31:0] and perf_mwait[31:0].
//      perf_stall: cycles with stallF=1.
//      perf_flush: mispredict events.
//      perf_mwait: MWAIT cycles.
//      All three saturate at 0xFFFFFFFF and clear on reset.
//  - Undefined: those ports are present but tied to 0; no counter logic.
// STRUCTURE
//  - Package pipe_ctrl_pkg: state enum ST_RUN/ST_MWAIT/ST_REDIR; constants FWD_RF=2'b00, FWD_MEM=2'b01, FWD_WB=2'b10.
//  - Sub-module pipe_fwd_sel: combinational forward select for one operand, instantiated twice (a, b).
// TESTING
//  1. Load to x5 in EX, ID reads x5 via rs2 -> one cycle of stallF=stallD=flushE=1, then fwd_bE=10 in the next EX.
//  2. Load in M, mem_readyM low 3 cycles -> 3 cycles all stalls=1 + flushW=1; 4th cycle released, state RUN.
//  3. MEM_TIMEOUT=4, mem_readyM stuck 0 -> mem_err rises after 4th MWAIT cycle, stays 1 until RST_N=0.
//  4. fail_predictE with REDIR_LAT=2 -> flushD=flushE=1, then flushD=1 for 2 cycles, then RUN.
//  5. fail_predictE while M waits -> ignored until mem_readyM=1, then flush; RST_N=0 mid-MWAIT -> RUN, wcnt=0.
//  6. rdM=rdW=rs1E=7, both writing, M not a load -> fwd_aE=01; rdM=0 -> fwd_aE=10.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the RV32I pipeline hazard controller.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_MWAIT = 2'd1,
    ST_REDIR = 2'd2
  } state_e;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

  // Saturating increment used by the optional performance counters.
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Pipeline-side bundle of the hazard controller: stage info in, stall/flush/forward controls out.
interface pipe_hazard_ctrl_if;
  logic [4:0]  rs1D;
  logic [4:0]  rs2D;
  logic        use_rs1D;
  logic        use_rs2D;
  logic [4:0]  rs1E;
  logic [4:0]  rs2E;
  logic [4:0]  rdE;
  logic        reg_writeE;
  logic [2:0]  mem_loadE;
  logic        fail_predictE;
  logic [4:0]  rdM;
  logic        reg_writeM;
  logic [2:0]  mem_loadM;
  logic [1:0]  mem_storeM;
  logic        mem_readyM;
  logic [4:0]  rdW;
  logic        reg_writeW;

  logic        stallF;
  logic        stallD;
  logic        stallE;
  logic        stallM;
  logic        flushD;
  logic        flushE;
  logic        flushW;
  logic [1:0]  fwd_aE;
  logic [1:0]  fwd_bE;
  logic        mem_err;
  logic [31:0] perf_stall;
  logic [31:0] perf_flush;
  logic [31:0] perf_mwait;

  // The pipeline datapath drives stage info and consumes the controls.
  modport master (
    output rs1D, rs2D, use_rs1D, use_rs2D, rs1E, rs2E, rdE, reg_writeE,
           mem_loadE, fail_predictE, rdM, reg_writeM, mem_loadM, mem_storeM,
           mem_readyM, rdW, reg_writeW,
    input  stallF, stallD, stallE, stallM, flushD, flushE, flushW,
           fwd_aE, fwd_bE, mem_err, perf_stall, perf_flush, perf_mwait
  );

  modport slave (
    input  rs1D, rs2D, use_rs1D, use_rs2D, rs1E, rs2E, rdE, reg_writeE,
           mem_loadE, fail_predictE, rdM, reg_writeM, mem_loadM, mem_storeM,
           mem_readyM, rdW, reg_writeW,
    output stallF, stallD, stallE, stallM, flushD, flushE, flushW,
           fwd_aE, fwd_bE, mem_err, perf_stall, perf_flush, perf_mwait
  );
endinterface

// File: rtl/pipe_fwd_sel.sv
// EX operand forward select for one source register; MEM result beats WB data.
module pipe_fwd_sel
  import pipe_ctrl_pkg::*;
(
  input  logic [4:0] rs_e,
  input  logic [4:0] rd_m,
  input  logic       reg_write_m,
  input  logic [2:0] mem_load_m,
  input  logic [4:0] rd_w,
  input  logic       reg_write_w,
  output logic [1:0] fwd
);

  // A load in MEM has no result yet, so it cannot forward from there.
  always_comb begin
    fwd = FWD_RF;
    if (reg_write_m && (rd_m != 5'd0) && (rd_m == rs_e) && (mem_load_m == 3'd0)) begin
      fwd = FWD_MEM;
    end else if (reg_write_w && (rd_w != 5'd0) && (rd_w == rs_e)) begin
      fwd = FWD_WB;
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/sequencing controller for the 5-stage RV32I pipeline (stall, flush, forward, mem watchdog).
// Optional counters perf_stall/perf_flush/perf_mwait are built when PIPE_PERF_CNT_EN is defined.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 255,
  parameter int REDIR_LAT   = 1
) (
  input  logic CLK,
  input  logic RST_N,
  pipe_hazard_ctrl_if.slave hz
);

  localparam logic [15:0] WCNT_LAST = 16'(MEM_TIMEOUT - 1);
  localparam logic [3:0]  RCNT_INIT = 4'(REDIR_LAT);

  state_e      state_q, state_d;
  logic [15:0] wcnt_q, wcnt_d;
  logic [3:0]  rcnt_q, rcnt_d;
  logic        mem_err_q, mem_err_d;

  logic       mem_wait;
  logic       timeout;
  logic       load_use;
  logic       mispredict;
  logic       stall_f, stall_d, stall_e, stall_m;
  logic       flush_d, flush_e, flush_w;
  logic [1:0] fwd_a, fwd_b;

  always_comb begin
    mem_wait = ((hz.mem_loadM != 3'd0) || (hz.mem_storeM != 2'd0)) && !hz.mem_readyM;
    timeout  = (state_q == ST_MWAIT) && (wcnt_q == WCNT_LAST);
    load_use = (hz.mem_loadE != 3'd0) && hz.reg_writeE && (hz.rdE != 5'd0) &&
               ((hz.use_rs1D && (hz.rs1D == hz.rdE)) ||
                (hz.use_rs2D && (hz.rs2D == hz.rdE)));
  end

  always_comb begin
    state_d    = state_q;
    wcnt_d     = wcnt_q;
    rcnt_d     = rcnt_q;
    mem_err_d  = mem_err_q;
    stall_f    = 1'b0;
    stall_d    = 1'b0;
    stall_e    = 1'b0;
    stall_m    = 1'b0;
    flush_d    = 1'b0;
    flush_e    = 1'b0;
    flush_w    = 1'b0;
    mispredict = 1'b0;

    if (state_q == ST_REDIR) begin
      // A memory wait during redirect freezes the countdown rather than leaving REDIR.
      if (mem_wait) begin
        {stall_f, stall_d, stall_e, stall_m} = 4'b1111;
        flush_w = 1'b1;
      end else begin
        flush_d = 1'b1;
        rcnt_d  = rcnt_q - 4'd1;
        if (rcnt_q == 4'd1) begin
          state_d = ST_RUN;
        end
      end
    end else if (mem_wait && !timeout) begin
      {stall_f, stall_d, stall_e, stall_m} = 4'b1111;
      flush_w = 1'b1;
      state_d = ST_MWAIT;
      if (state_q == ST_MWAIT) begin
        wcnt_d = wcnt_q + 16'd1;
      end
    end else begin
      // Free-running cycle: also covers the release cycle of a wait or a watchdog abort.
      state_d = ST_RUN;
      wcnt_d  = 16'd0;
      if (mem_wait) begin
        mem_err_d = 1'b1;
      end
      if (hz.fail_predictE) begin
        flush_d    = 1'b1;
        flush_e    = 1'b1;
        mispredict = 1'b1;
        if (REDIR_LAT > 0) begin
          state_d = ST_REDIR;
          rcnt_d  = RCNT_INIT;
        end
      end else if (load_use) begin
        stall_f = 1'b1;
        stall_d = 1'b1;
        flush_e = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q   <= ST_RUN;
      wcnt_q    <= 16'd0;
      rcnt_q    <= 4'd0;
      mem_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wcnt_q    <= wcnt_d;
      rcnt_q    <= rcnt_d;
      mem_err_q <= mem_err_d;
    end
  end

  pipe_fwd_sel u_fwd_a (
    .rs_e        (hz.rs1E),
    .rd_m        (hz.rdM),
    .reg_write_m (hz.reg_writeM),
    .mem_load_m  (hz.mem_loadM),
    .rd_w        (hz.rdW),
    .reg_write_w (hz.reg_writeW),
    .fwd         (fwd_a)
  );

  pipe_fwd_sel u_fwd_b (
    .rs_e        (hz.rs2E),
    .rd_m        (hz.rdM),
    .reg_write_m (hz.reg_writeM),
    .mem_load_m  (hz.mem_loadM),
    .rd_w        (hz.rdW),
    .reg_write_w (hz.reg_writeW),
    .fwd         (fwd_b)
  );

  // While reset is held, every stage register is bubbled and nothing forwards.
  assign hz.stallF  = RST_N & stall_f;
  assign hz.stallD  = RST_N & stall_d;
  assign hz.stallE  = RST_N & stall_e;
  assign hz.stallM  = RST_N & stall_m;
  assign hz.flushD  = !RST_N | flush_d;
  assign hz.flushE  = !RST_N | flush_e;
  assign hz.flushW  = !RST_N | flush_w;
  assign hz.fwd_aE  = RST_N ? fwd_a : FWD_RF;
  assign hz.fwd_bE  = RST_N ? fwd_b : FWD_RF;
  assign hz.mem_err = mem_err_q;

`ifdef PIPE_PERF_CNT_EN
  logic [31:0] perf_stall_q, perf_stall_d;
  logic [31:0] perf_flush_q, perf_flush_d;
  logic [31:0] perf_mwait_q, perf_mwait_d;

  always_comb begin
    perf_stall_d = stall_f ? sat_inc(perf_stall_q) : perf_stall_q;
    perf_flush_d = mispredict ? sat_inc(perf_flush_q) : perf_flush_q;
    perf_mwait_d = (state_q == ST_MWAIT) ? sat_inc(perf_mwait_q) : perf_mwait_q;
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      perf_stall_q <= 32'd0;
      perf_flush_q <= 32'd0;
      perf_mwait_q <= 32'd0;
    end else begin
      perf_stall_q <= perf_stall_d;
      perf_flush_q <= perf_flush_d;
      perf_mwait_q <= perf_mwait_d;
    end
  end

  assign hz.perf_stall = perf_stall_q;
  assign hz.perf_flush = perf_flush_q;
  assign hz.perf_mwait = perf_mwait_q;
`else
  assign hz.perf_stall = 32'd0;
  assign hz.perf_flush = 32'd0;
  assign hz.perf_mwait = 32'd0;
`endif

endmodule
